// File: rtl/string_job_sequencer.sv
// Job sequencer for the string engine: buffers A/B operand words, issues one
// engine operation per word pair and queues the engine results for software.
module string_job_sequencer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_a,
  input  logic                     load_b,
  input  logic [31:0]              wdata,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   num_words,
  input  logic [2:0]               char_len,
  input  logic                     clr_done,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               err_code,
  output logic [$clog2(DEPTH):0]   a_count,
  output logic [$clog2(DEPTH):0]   b_count,
  output logic [$clog2(DEPTH):0]   res_count,
  input  logic                     res_pop,
  output logic [31:0]              res_data,
  output logic                     eng_go,
  output logic [31:0]              eng_a,
  output logic [31:0]              eng_b,
  output logic [2:0]               eng_index,
  output logic [2:0]               eng_length,
  input  logic                     eng_done,
  input  logic [31:0]              eng_result
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = 8;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STORE, FINISH} state_t;

  state_t        state;
  logic [31:0]   a_mem [DEPTH];
  logic [31:0]   b_mem [DEPTH];
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] a_rd, a_wr, b_rd, b_wr, r_rd, r_wr;
  logic [CW-1:0] remaining;
  logic [2:0]    index;
  logic [TW-1:0] timer;
  logic [31:0]   res_hold;

  logic          start_ok, accept, reject, issue_entry, timeout_hit;
  logic          a_pop, b_pop, a_push, b_push, r_push, r_pop;
  logic          a_ovf, b_ovf, r_ovf;
  logic [1:0]    err_next;

  // Handshake decode shared by the FSM and the FIFO bookkeeping.
  always_comb begin
    start_ok    = (num_words <= a_count) && (num_words <= b_count) &&
                  (num_words <= (CW'(DEPTH) - res_count));
    accept      = (state == IDLE) && start && (num_words != '0) && start_ok;
    reject      = (state == IDLE) && start && (num_words != '0) && !start_ok;
    issue_entry = accept || ((state == STORE) && (remaining != CW'(1)));
    a_pop       = issue_entry && (a_count != '0);
    b_pop       = issue_entry && (b_count != '0);
    a_push      = load_a && ((a_count != CW'(DEPTH)) || a_pop);
    b_push      = load_b && ((b_count != CW'(DEPTH)) || b_pop);
    r_pop       = res_pop && (res_count != '0);
    r_push      = (state == STORE) && ((res_count != CW'(DEPTH)) || r_pop);
    a_ovf       = load_a && !a_push;
    b_ovf       = load_b && !b_push;
    r_ovf       = (state == STORE) && !r_push;
    timeout_hit = (state == WAIT) && !eng_done && (timer == TW'(TIMEOUT));
    err_next    = 2'd0;
    if (timeout_hit)                err_next = 2'd3;
    else if (a_ovf || b_ovf || r_ovf) err_next = 2'd2;
    else if (reject)                err_next = 2'd1;
  end

  assign res_data = (res_count != '0) ? r_mem[r_rd] : 32'd0;

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (a_push) a_mem[a_wr] <= wdata;
    if (b_push) b_mem[b_wr] <= wdata;
    if (r_push) r_mem[r_wr] <= res_hold;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rd <= '0; a_wr <= '0; a_count   <= '0;
      b_rd <= '0; b_wr <= '0; b_count   <= '0;
      r_rd <= '0; r_wr <= '0; res_count <= '0;
    end else begin
      if (a_push) a_wr <= a_wr + AW'(1);
      if (a_pop)  a_rd <= a_rd + AW'(1);
      if (a_push && !a_pop)      a_count <= a_count + CW'(1);
      else if (!a_push && a_pop) a_count <= a_count - CW'(1);
      if (b_push) b_wr <= b_wr + AW'(1);
      if (b_pop)  b_rd <= b_rd + AW'(1);
      if (b_push && !b_pop)      b_count <= b_count + CW'(1);
      else if (!b_push && b_pop) b_count <= b_count - CW'(1);
      if (r_push) r_wr <= r_wr + AW'(1);
      if (r_pop)  r_rd <= r_rd + AW'(1);
      if (r_push && !r_pop)      res_count <= res_count + CW'(1);
      else if (!r_push && r_pop) res_count <= res_count - CW'(1);
    end
  end

  // Sequencer FSM; operands and eng_go are loaded on the edge entering ISSUE
  // so the engine sees them for the whole ISSUE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_code   <= 2'd0;
      eng_go     <= 1'b0;
      eng_a      <= 32'd0;
      eng_b      <= 32'd0;
      eng_index  <= 3'd0;
      eng_length <= 3'd0;
      remaining  <= '0;
      index      <= 3'd0;
      timer      <= '0;
      res_hold   <= 32'd0;
    end else begin
      eng_go <= 1'b0;
      if (clr_done) begin
        done     <= 1'b0;
        err_code <= 2'd0;
      end
      case (state)
        IDLE: begin
          if (start && (num_words == '0)) begin
            done     <= 1'b1;
            err_code <= 2'd0;
          end else if (accept) begin
            done       <= 1'b0;
            err_code   <= 2'd0;
            busy       <= 1'b1;
            remaining  <= num_words;
            eng_length <= char_len;
            index      <= 3'd0;
            eng_index  <= 3'd0;
            eng_go     <= 1'b1;
            eng_a      <= a_mem[a_rd];
            eng_b      <= b_mem[b_rd];
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (eng_done) begin
            res_hold <= eng_result;
            state    <= STORE;
          end else if (timeout_hit) begin
            state <= FINISH;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        STORE: begin
          remaining <= remaining - CW'(1);
          index     <= index + 3'd1;
          if (remaining == CW'(1)) begin
            state <= FINISH;
          end else begin
            eng_go    <= 1'b1;
            eng_a     <= a_mem[a_rd];
            eng_b     <= b_mem[b_rd];
            eng_index <= index + 3'd1;
            state     <= ISSUE;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (err_next != 2'd0) err_code <= err_next;
    end
  end

endmodule

// File: tb/tb_string_job_sequencer.sv
// Scoreboard bench for string_job_sequencer with an XOR-echo engine model.
module tb_string_job_sequencer;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned CW      = 5;
  localparam int          TIMEOUT = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_a = 1'b0, load_b = 1'b0;
  logic [31:0]   wdata = 32'd0;
  logic          start = 1'b0;
  logic [CW-1:0] num_words = '0;
  logic [2:0]    char_len = 3'd4;
  logic          clr_done = 1'b0;
  logic          busy, done;
  logic [1:0]    err_code;
  logic [CW-1:0] a_count, b_count, res_count;
  logic          res_pop = 1'b0;
  logic [31:0]   res_data;
  logic          eng_go;
  logic [31:0]   eng_a, eng_b;
  logic [2:0]    eng_index, eng_length;
  logic          eng_done = 1'b0;
  logic [31:0]   eng_result = 32'd0;
  logic          eng_en = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] a_q[$], b_q[$], exp_q[$];

  string_job_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .load_a(load_a), .load_b(load_b), .wdata(wdata),
    .start(start), .num_words(num_words), .char_len(char_len), .clr_done(clr_done),
    .busy(busy), .done(done), .err_code(err_code), .a_count(a_count),
    .b_count(b_count), .res_count(res_count), .res_pop(res_pop), .res_data(res_data),
    .eng_go(eng_go), .eng_a(eng_a), .eng_b(eng_b), .eng_index(eng_index),
    .eng_length(eng_length), .eng_done(eng_done), .eng_result(eng_result)
  );

  always #5 clk = ~clk;

  // Engine model: answers each eng_go one cycle later with A^B.
  always @(posedge clk) begin
    eng_done <= 1'b0;
    if (eng_go && eng_en) begin
      eng_done   <= 1'b1;
      eng_result <= eng_a ^ eng_b;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input bit to_b, input logic [31:0] v);
    wdata = v;
    if (to_b) begin
      load_b = 1'b1;
      if (b_q.size() < DEPTH) b_q.push_back(v);
    end else begin
      load_a = 1'b1;
      if (a_q.size() < DEPTH) a_q.push_back(v);
    end
    @(negedge clk);
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      check("res_count", 32'(res_count), 32'(exp_q.size()));
      check("res_data", res_data, exp_q[0]);
      void'(exp_q.pop_front());
      res_pop = 1'b1;
      @(negedge clk);
      res_pop = 1'b0;
    end
    check("res_count_empty", 32'(res_count), 32'd0);
    check("res_data_empty", res_data, 32'd0);
  endtask

  // Runs one accepted job from a negedge; echo=0 means the engine stays silent.
  task automatic job(input int n, input bit echo, input bit with_push,
                     input bit pop_in_store, input bit start_busy, input bit clr_edge);
    int cycles, gos, exp_idx, exp_done;
    logic [31:0] cnt_before;
    bit arm, popped;
    logic [31:0] ea_q[$], eb_q[$];
    logic [31:0] xa, xb;
    gos = 0; exp_idx = 0; arm = 0; popped = 0; cnt_before = 0;
    num_words = CW'(n);
    start = 1'b1;
    if (with_push) begin
      load_a = 1'b1;
      wdata = 32'hABCD_0000 + 32'(n);
      a_q.push_back(wdata);
    end
    for (int i = 0; i < (echo ? n : 1); i++) begin
      xa = a_q.pop_front();
      xb = b_q.pop_front();
      ea_q.push_back(xa);
      eb_q.push_back(xb);
      if (echo) exp_q.push_back(xa ^ xb);
    end
    exp_done = echo ? 3 * n + 2 : TIMEOUT + 4;
    @(posedge clk); #1;
    start = 1'b0;
    load_a = 1'b0;
    cycles = 1;
    check("busy_t1", 32'(busy), 32'd1);
    check("go_t1", 32'(eng_go), 32'd1);
    if (with_push) check("a_count_push_pop", 32'(a_count), 32'(a_q.size() + n - 1));
    while (1) begin
      if (eng_go) begin
        gos++;
        check("eng_index", 32'(eng_index), 32'(exp_idx % 8));
        check("eng_length", 32'(eng_length), 32'(char_len));
        if (exp_idx < ea_q.size()) begin
          check("eng_a", eng_a, ea_q[exp_idx]);
          check("eng_b", eng_b, eb_q[exp_idx]);
        end
        exp_idx++;
      end
      if (done) break;
      if (cycles >= 600) begin
        check("done_timeout", 32'(done), 32'd1);
        break;
      end
      if (res_pop) begin
        res_pop = 1'b0;
        check("res_count_store_pop", 32'(res_count), cnt_before);
      end
      if (arm) begin
        arm = 0;
        cnt_before = 32'(res_count);
        check("res_data_store_pop", res_data, exp_q[0]);
        void'(exp_q.pop_front());
        res_pop = 1'b1;
      end
      if (pop_in_store && eng_done && !popped) begin
        arm = 1;
        popped = 1;
      end
      start    = start_busy && (cycles == 2);
      clr_done = clr_edge && (cycles == exp_done - 1);
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    clr_done = 1'b0;
    res_pop = 1'b0;
    check("done_cycle", 32'(cycles), 32'(exp_done));
    if (clr_edge) check("done_after_clr", 32'(done), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    check("err_end", 32'(err_code), echo ? 32'd0 : 32'd3);
    check("go_count", 32'(gos), echo ? 32'(n) : 32'd1);
    check("a_count_end", 32'(a_count), 32'(a_q.size()));
    check("b_count_end", 32'(b_count), 32'(b_q.size()));
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_code), 32'd0);
    check("rst_counts", 32'({a_count, b_count, res_count}), 32'd0);
    check("rst_go", 32'(eng_go), 32'd0);
    check("rst_eng", eng_a | eng_b | 32'({eng_index, eng_length}), 32'd0);
    check("rst_res_data", res_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic job: results 5,7,5, done at start+11.
    for (int i = 1; i <= 3; i++) push_word(1'b0, 32'(i));
    for (int i = 4; i <= 6; i++) push_word(1'b1, 32'(i));
    char_len = 3'd4;
    job(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // Zero-length start sets done and stays idle.
    clr_done = 1'b1; @(negedge clk); clr_done = 1'b0;
    check("clr_done", 32'(done), 32'd0);
    num_words = '0; start = 1'b1; @(negedge clk); start = 1'b0;
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);

    // Underrun rejection.
    push_word(1'b0, 32'd10); push_word(1'b0, 32'd11);
    for (int i = 20; i <= 22; i++) push_word(1'b1, 32'(i));
    num_words = CW'(3); start = 1'b1; @(negedge clk); start = 1'b0;
    check("underrun_err", 32'(err_code), 32'd1);
    check("underrun_busy", 32'(busy), 32'd0);
    check("underrun_go", 32'(eng_go), 32'd0);
    @(negedge clk);
    check("underrun_go2", 32'(eng_go), 32'd0);
    clr_done = 1'b1; @(negedge clk); clr_done = 1'b0;
    check("underrun_clr", 32'(err_code), 32'd0);
    push_word(1'b0, 32'd12);
    char_len = 3'd2;
    job(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // Full A FIFO and pointer wrap over two 16-word jobs.
    for (int i = 0; i < 17; i++) push_word(1'b0, 32'h100 + 32'(i));
    check("full_a_count", 32'(a_count), 32'd16);
    check("full_err", 32'(err_code), 32'd2);
    for (int i = 0; i < 16; i++) push_word(1'b1, 32'h5500_0000 + 32'(i * 7));
    job(16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    for (int i = 0; i < 16; i++) begin
      push_word(1'b0, $urandom);
      push_word(1'b1, $urandom);
    end
    char_len = 3'd0;
    job(16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // Timeout: silent engine, remaining words stay queued.
    for (int i = 0; i < 3; i++) begin
      push_word(1'b0, 32'h700 + 32'(i));
      push_word(1'b1, 32'h800 + 32'(i));
    end
    eng_en = 1'b0;
    job(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    eng_en = 1'b1;

    // Simultaneous events: push on pop, start while busy, clr on done edge,
    // then a result pop during STORE.
    char_len = 3'd3;
    job(2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    push_word(1'b1, 32'hC0DE);
    job(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();

    // Reset in the middle of WAIT, then a fresh job.
    push_word(1'b0, 32'h11); push_word(1'b0, 32'h22);
    push_word(1'b1, 32'h33); push_word(1'b1, 32'h44);
    eng_en = 1'b0;
    num_words = CW'(2); start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1; #1;
    check("mid_rst_counts", 32'({a_count, b_count, res_count}), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_go", 32'(eng_go), 32'd0);
    check("mid_rst_flags", 32'({done, err_code}), 32'd0);
    a_q.delete(); b_q.delete(); exp_q.delete();
    eng_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push_word(1'b0, 32'hF0F0); push_word(1'b0, 32'h0F0F);
    push_word(1'b1, 32'h1234); push_word(1'b1, 32'h8765);
    job(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/string_job_sequencer.md
# string_job_sequencer

Sequences multi-word jobs through the string hardware engine (the `go`/`done` datapath taking 32-bit operands A and B plus `index`/`length` and returning a 32-bit result). It buffers operand words pushed from the Avalon register front end in two FIFOs. On `start` it issues one engine operation per A/B word pair and collects each engine result into a result FIFO for software to drain. It sits between the Avalon slave and the engine and is the only driver of the engine's control inputs.

## Interface
- DEPTH, 16, entries per FIFO (A, B, result); power of two, ≥2
- TIMEOUT, 255, max cycles in WAIT before abort; 8-bit range
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- load_a  in  1  push `wdata` into A FIFO
- load_b  in  1  push `wdata` into B FIFO
- wdata  in  32  operand write data
- start  in  1  single-cycle job start request
- num_words  in  log2(DEPTH)+1  word pairs in job, 0..DEPTH
- char_len  in  3  byte length passed to engine, 0..4
- clr_done  in  1  clears `done` and `err_code`
- busy  out  1  job in progress
- done  out  1  sticky job-complete flag
- err_code  out  2  sticky: 0 none, 1 underrun/no space, 2 overflow, 3 timeout
- a_count, b_count, res_count  out  log2(DEPTH)+1  FIFO occupancies
- res_pop  in  1  pop result FIFO head
- res_data  out  32  result FIFO head, combinational from storage; 0 when empty
- eng_go  out  1  engine start pulse
- eng_a, eng_b  out  32  engine operands
- eng_index  out  3  word index within job, modulo 8
- eng_length  out  3  latched `char_len`
- eng_done  in  1  engine completion
- eng_result  in  32  engine result, valid with `eng_done`

## Operation
- Reset values: all outputs 0; FIFOs empty; FSM in IDLE.
- FIFOs: circular, separate read and write pointers that wrap modulo DEPTH, plus a count.
  - A push when full is dropped and sets err_code=2.
  - Push and pop in the same cycle leave the count unchanged, including when full.
  - `res_pop` when empty is ignored.
- FSM states: IDLE, ISSUE, WAIT, STORE, FINISH.
- IDLE, with `start`:
  - num_words=0: done←1; stay in IDLE.
  - num_words > a_count, num_words > b_count, or num_words > DEPTH−res_count: err_code←1; job rejected; stay in IDLE.
  - Otherwise: latch remaining←num_words, eng_length←char_len, index←0, busy←1; go to ISSUE.
  - An accepted or zero-length start also clears done and err_code.
- ISSUE, 1 cycle: pop the A and B heads into eng_a/eng_b; eng_go=1; eng_index=index; go to WAIT.
- WAIT:
  - eng_done=1: capture eng_result; go to STORE.
  - No eng_done after TIMEOUT cycles: err_code←3; go to FINISH, abandoning the remaining words (they stay in the FIFOs).
- STORE, 1 cycle: push the captured result; remaining−1; index+1 (wraps 7→0).
  - remaining becomes 0: go to FINISH. Otherwise: go to ISSUE.
- FINISH, 1 cycle: busy←0 and done←1 at the exit edge; go to IDLE.
- `start` while busy is ignored. `eng_done` outside WAIT is ignored.
- `clr_done` in the same cycle as done being set: the set wins.
- Overflow (err_code=2) during a job does not abort the job.
- Error priority when several errors occur in one cycle: 3 > 2 > 1.

## Timing
- `start` sampled at edge T and accepted: busy=1 and eng_go=1 in cycle T+1.
- eng_go is a one-cycle pulse per word. eng_a, eng_b and eng_index hold until the next ISSUE.
- Engine answering in the first WAIT cycle: 3 cycles per word.
- N-word job with minimum engine latency: done rises 3N+2 cycles after the start edge (the extra 2 cycles are ISSUE entry and FINISH).
- Result pushes are visible on res_count the cycle after STORE.
- res_data updates the cycle after a res_pop.
- Reset asserted mid-job: immediately returns everything to reset values, drops eng_go, and discards FIFO contents.

## Test plan
- Basic job: push A={1,2,3}, B={4,5,6}, char_len=4, start num_words=3, engine echoes A^B with 1-cycle latency.
  - Required: eng_go×3 with eng_index 0,1,2; res FIFO holds 5,7,5; done at start+11; a_count=b_count=0.
- Underrun: a_count=2, b_count=3, start num_words=3.
  - Required: err_code=1, busy stays 0, no eng_go.
  - Then clr_done: err_code=0.
- FIFO full and wrap: push 17 A words.
  - Required: a_count=16, err_code=2.
  - Then run 16-word jobs twice with refills: pointer wrap is correct and result order is preserved.
- Timeout: engine never asserts eng_done, TIMEOUT=255.
  - Required: err_code=3, done=1 and busy=0 after WAIT exceeds 255 cycles; remaining A/B words intact.
- Simultaneous events: load_a during ISSUE keeps a_count consistent; res_pop during STORE keeps res_count unchanged; start while busy is ignored; clr_done on the done edge leaves done=1.
- Reset mid-WAIT: all counts 0, busy=0, eng_go=0; a fresh job then completes normally.
